// File: rtl/shift_rot_seq.sv
// ---------------------------------------------------------------------------
// shift_rot_seq
//
// Multi-cycle shift/rotate sequencer that sits beside the ALU. The control
// unit starts it for SHR, SHRA, SHL, ROR and ROL. It then waits on o_done
// before latching o_result into Z.
//
// The operand is stepped one bit position per RUN cycle until the captured
// count is used up. The result is then published together with a one-cycle
// done pulse.
//
// Build option:
//   SHIFT_ROT_STEP4_EN - when defined, a RUN cycle moves 4 positions while
//                        at least 4 remain, otherwise 1. Results are
//                        identical to the default build; only latency
//                        shrinks.
//
// Ports:
//   i_clk      system clock, all state changes on the rising edge
//   i_clr      synchronous active-high reset, wins over i_start
//   i_start    operation request, honoured only in IDLE or DONE
//   i_op       3'b000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL,
//              101..111 illegal (result = operand)
//   i_a        32-bit operand, captured on an accepted start
//   i_b        5-bit count, captured on an accepted start
//   o_busy     high while the operation is iterating (RUN)
//   o_done     one-cycle pulse in the cycle after o_result is updated
//   o_result   registered result, held until the next done
// ---------------------------------------------------------------------------
module shift_rot_seq (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [4:0]  i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_work;
  logic [4:0]  r_cnt;
  logic [2:0]  r_opQ;
  logic [31:0] r_result;

  logic        w_accept;
  logic        w_direct;
  logic [31:0] w_step1;
  logic [31:0] w_stepped;
  logic [4:0]  w_stepAmt;
  logic [4:0]  w_cntNext;
  logic        w_lastStep;

  // A new request may only be taken when no operation is iterating. Taking
  // it in DONE is what allows back-to-back operations with no idle cycle.
  always_comb begin
    w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));
    w_direct = (i_b == 5'd0) || (i_op > OP_ROL);
  end

  // Single-position step of the working register for the captured opcode.
  // The default arm is never exercised in RUN, because illegal opcodes
  // bypass RUN entirely.
  always_comb begin
    w_step1 = r_work;
    case (r_opQ)
      OP_SHR:  w_step1 = {1'b0, r_work[31:1]};
      OP_SHRA: w_step1 = {r_work[31], r_work[31:1]};
      OP_SHL:  w_step1 = {r_work[30:0], 1'b0};
      OP_ROR:  w_step1 = {r_work[0], r_work[31:1]};
      OP_ROL:  w_step1 = {r_work[30:0], r_work[31]};
      default: w_step1 = r_work;
    endcase
  end

`ifdef SHIFT_ROT_STEP4_EN
  logic [31:0] w_step4;

  // Four-position step with the same fill and wrap rules as the single
  // step. It is used only while at least four positions remain, so the
  // count can never underflow.
  always_comb begin
    w_step4 = r_work;
    case (r_opQ)
      OP_SHR:  w_step4 = {4'b0000, r_work[31:4]};
      OP_SHRA: w_step4 = {{4{r_work[31]}}, r_work[31:4]};
      OP_SHL:  w_step4 = {r_work[27:0], 4'b0000};
      OP_ROR:  w_step4 = {r_work[3:0], r_work[31:4]};
      OP_ROL:  w_step4 = {r_work[27:0], r_work[31:28]};
      default: w_step4 = r_work;
    endcase
  end

  // Choose the wide step while it still fits in the remaining count.
  always_comb begin
    if (r_cnt >= 5'd4) begin
      w_stepped = w_step4;
      w_stepAmt = 5'd4;
    end else begin
      w_stepped = w_step1;
      w_stepAmt = 5'd1;
    end
  end
`else
  // Only the single-position step exists in this build.
  always_comb begin
    w_stepped = w_step1;
    w_stepAmt = 5'd1;
  end
`endif

  // Remaining count after this cycle's step. Reaching zero means this step
  // produces the final value.
  always_comb begin
    w_cntNext  = r_cnt - w_stepAmt;
    w_lastStep = (w_cntNext == 5'd0);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. DONE lasts a single cycle unless a new request
  // arrives in it. A zero count or an illegal opcode skips RUN.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_nextState = w_direct ? DONE : RUN;
        end else begin
          w_nextState = IDLE;
        end
      end
      RUN: begin
        if (w_lastStep) begin
          w_nextState = DONE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath. Operands are captured on acceptance, so later input changes
  // have no effect. The result register is written only on the edge that
  // enters DONE, which keeps it stable through the following operation.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_work   <= '0;
      r_cnt    <= '0;
      r_opQ    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_work <= i_a;
      r_cnt  <= i_b;
      r_opQ  <= i_op;
      if (w_direct) begin
        r_result <= i_a;
      end
    end else if (r_state == RUN) begin
      r_work <= w_stepped;
      r_cnt  <= w_cntNext;
      if (w_lastStep) begin
        r_result <= w_stepped;
      end
    end
  end

  // Outputs are decoded straight from registers, so no input reaches an
  // output combinationally.
  assign o_busy   = (r_state == RUN);
  assign o_done   = (r_state == DONE);
  assign o_result = r_result;

endmodule

// File: tb/tb_shift_rot_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_rot_seq
//
// Self-checking bench for shift_rot_seq. Each accepted request pushes its
// expected result and its start/done edge numbers onto a scoreboard. A
// monitor on the falling edge then does three things every cycle:
//   - checks busy against the head entry's window;
//   - pops and compares the head entry when its done edge arrives;
//   - otherwise requires done low and the result held.
// Expected values come from a behavioural shift/rotate model and a latency
// formula, and follow SHIFT_ROT_STEP4_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_shift_rot_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [4:0]  b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          tEdge;
    int          eEdge;
  } exp_t;

  exp_t        sbQ[$];
  int          cycleCount = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] lastResult = 32'h0;
  logic        monOn = 1'b0;

  shift_rot_seq dut (
    .i_clk    (clk),
    .i_clr    (clr),
    .i_start  (start),
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  // Clock generation and a count of rising edges seen so far.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, obs, expv, cycleCount);
    end
  endtask

  // Behavioural reference: whole-amount shifts and rotates in one step.
  function automatic logic [31:0] modelResult(input logic [2:0] mop, input logic [31:0] ma, input logic [4:0] mb);
    logic [31:0] r;
    int          sh;
    sh = int'(mb);
    if (mb == 5'd0 || mop > 3'd4) return ma;
    case (mop)
      3'd0:    r = ma >> sh;
      3'd1:    r = $signed(ma) >>> sh;
      3'd2:    r = ma << sh;
      3'd3:    r = (ma >> sh) | (ma << (32 - sh));
      default: r = (ma << sh) | (ma >> (32 - sh));
    endcase
    return r;
  endfunction

  // Cycles from the accepting edge to the edge that samples done high.
  function automatic int modelLatency(input logic [2:0] mop, input logic [4:0] mb);
    int n;
    n = int'(mb);
    if (mb == 5'd0 || mop > 3'd4) return 1;
`ifdef SHIFT_ROT_STEP4_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  // Drive one start pulse from a falling edge. If the DUT should accept it,
  // record the expectation. Inputs are scrambled afterwards so that any
  // late sampling shows up.
  task automatic applyStimulus(input logic [2:0] sop, input logic [31:0] sa, input logic [4:0] sb, input bit accepted);
    exp_t e;
    op    = sop;
    a     = sa;
    b     = sb;
    start = 1'b1;
    if (accepted) begin
      e.res   = modelResult(sop, sa, sb);
      e.tEdge = cycleCount + 1;
      e.eEdge = e.tEdge + modelLatency(sop, sb) - 1;
      sbQ.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    op    = 3'($urandom);
    a     = $urandom;
    b     = 5'($urandom);
  endtask

  // Stay on falling edges until done is observed, with a cycle bound.
  task automatic waitForDone(input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!done) checkOutput("timeout_done", 32'(done), 32'd1);
  endtask

  // Wait until every expected result has been seen, with a cycle bound.
  task automatic waitDrain(input int bound);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      checkOutput("timeout_drain", 32'(sbQ.size()), 32'd0);
      sbQ.delete();
    end
    @(negedge clk);
  endtask

  // Per-cycle monitor: busy window, done timing, result value and hold.
  always @(negedge clk) begin
    if (monOn) begin
      logic expBusy;
      expBusy = 1'b0;
      if (sbQ.size() > 0 && sbQ[0].tEdge <= cycleCount && cycleCount < sbQ[0].eEdge) expBusy = 1'b1;
      checkOutput("busy", 32'(busy), 32'(expBusy));
      if (sbQ.size() > 0 && sbQ[0].eEdge == cycleCount) begin
        checkOutput("done", 32'(done), 32'd1);
        checkOutput("result", result, sbQ[0].res);
        lastResult = sbQ[0].res;
        void'(sbQ.pop_front());
      end else begin
        checkOutput("done_idle", 32'(done), 32'd0);
        checkOutput("result_hold", result, lastResult);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr   = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'h0;
    b     = 5'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_result", result, 32'h0);
    clr   = 1'b0;
    monOn = 1'b1;
    @(negedge clk);

    $display("[TB] ROL by 1");
    applyStimulus(3'd4, 32'h8000_0001, 5'd1, 1'b1);
    waitDrain(64);

    $display("[TB] SHRA by 4");
    applyStimulus(3'd1, 32'hF000_0000, 5'd4, 1'b1);
    waitDrain(64);

    $display("[TB] ROR by 31");
    applyStimulus(3'd3, 32'h0000_0001, 5'd31, 1'b1);
    waitDrain(64);

    $display("[TB] zero count then illegal opcode back-to-back");
    applyStimulus(3'd3, 32'h1234_5678, 5'd0, 1'b1);
    waitForDone(8);
    applyStimulus(3'd7, 32'hDEAD_BEEF, 5'd5, 1'b1);
    waitDrain(64);

    $display("[TB] SHL by 16 with ignored start, then SHR back-to-back");
    applyStimulus(3'd2, 32'h0000_FFFF, 5'd16, 1'b1);
    repeat (2) @(negedge clk);
    applyStimulus(3'd4, 32'hA5A5_A5A5, 5'd3, 1'b0);
    waitForDone(64);
    applyStimulus(3'd0, 32'hFFFF_0000, 5'd16, 1'b1);
    waitDrain(64);

    $display("[TB] boundary counts");
    applyStimulus(3'd2, 32'h0000_0003, 5'd31, 1'b1);
    waitDrain(64);
    applyStimulus(3'd1, 32'h8000_0000, 5'd31, 1'b1);
    waitDrain(64);
    applyStimulus(3'd4, 32'h8765_4321, 5'd7, 1'b1);
    waitDrain(64);

    $display("[TB] clear during RUN");
    applyStimulus(3'd0, 32'hCAFE_F00D, 5'd10, 1'b1);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    sbQ.delete();
    lastResult = 32'h0;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clr_busy", 32'(busy), 32'd0);
    checkOutput("clr_done", 32'(done), 32'd0);
    checkOutput("clr_result", result, 32'h0);
    repeat (15) @(negedge clk);

    $display("[TB] random back-to-back chain");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), $urandom, 5'($urandom), 1'b1);
      waitForDone(64);
    end
    waitDrain(64);

    repeat (3) @(negedge clk);
    monOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_rot_seq.md
# shift_rot_seq

Multi-cycle shift/rotate sequencer for the CPU ALU. It accepts a 32-bit operand, a 5-bit count and a shift/rotate opcode, then iterates the operand one position per cycle, or four with the step option, until the count is exhausted. It returns the result with a one-cycle done pulse. It sits beside the ALU and is started by the control unit for SHR, SHRA, SHL, ROR and ROL instructions. The control unit waits on `done` before latching the result into Z.

## Interface
Parameters:
- none (width fixed at 32 data bits, 5 count bits)

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge
- `clr`  in  1  reset, synchronous, active-high
- `start`  in  1  request; sampled only in IDLE or DONE
- `op`  in  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, 101–111 illegal
- `A`  in  32  operand, captured on accepted start
- `B`  in  5  shift/rotate count, captured on accepted start
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse when `result` is updated
- `result`  out  32  registered result; holds until the next `done`

## Operation
- States: IDLE, RUN, DONE. Registers: `work[31:0]`, `cnt[4:0]`, `op_q[2:0]`, `result`.
- **Accepted start:** `start`=1 in IDLE or DONE. On that edge, `work`←A, `cnt`←B and `op_q`←op.
  - If B=0 or op is illegal, next state is DONE.
  - Otherwise next state is RUN.
- **RUN, each cycle:** apply one step to `work` per `op_q`, then decrement `cnt`.
  - SHR: logical right shift, zero fill.
  - SHRA: arithmetic right shift, bit 31 replicated.
  - SHL: left shift, zero fill.
  - ROR: `work[0]` goes to bit 31.
  - ROL: `work[31]` goes to bit 0.
- **Leaving RUN:** when the step consumes the final count, `result`←stepped `work` and the next state is DONE.
- **Entering DONE directly** (B=0 or illegal op): `result`←A unchanged.
- **DONE:** `done`=1 for exactly one cycle.
  - The next state is RUN or DONE if a start is accepted in this cycle, per the start rules above.
  - Otherwise the next state is IDLE.
- `start` in RUN is ignored. No queueing, no error flag.
- Changes on `A`, `B` or `op` after acceptance have no effect.
- Count arithmetic is unsigned 5-bit, so the maximum is 31 positions. A rotate by 31 equals a rotate by 1 in the opposite direction.
- **`clr` reset values:** state=IDLE, `busy`=0, `done`=0, `result`=0, `work`=0, `cnt`=0.
  - `clr` has priority over `start`.
  - `clr` mid-RUN aborts the operation with no `done` pulse.

## Timing
- Accepted start at edge T:
  - `busy`=1 from T through the edge that enters DONE.
  - `done`=1 for the cycle after that edge.
- **Latency without step option:** B=0 gives `done` at T+1; otherwise `done` at T+B+1.
- **Back-to-back:** a start accepted during the DONE cycle gives zero idle cycles between operations.
- `result` changes only on the edge that asserts `done`. It is stable for the entire following operation, including during RUN.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **Macro `SHIFT_ROT_STEP4_EN` defined:** each RUN cycle moves 4 positions when `cnt`≥4, otherwise 1 position.
  - Shift fill and rotate wrap rules are identical to single steps.
  - Latency is floor(B/4)+(B mod 4)+1 cycles for B>0.
  - Adds a second 4-bit step mux.
- **Not defined:** always 1 position per cycle; latency is B+1 cycles.
- Results are bit-identical in both builds; only latency differs.

## Test plan
- ROL, A=0x80000001, B=1, start at T → `result`=0x00000003; `done` at T+2; `busy` high 1 cycle.
- SHRA, A=0xF0000000, B=4 → `result`=0xFF000000.
  - Without macro: `done` at T+5.
  - With macro: `done` at T+2.
- ROR, A=0x00000001, B=31 → `result`=0x00000002.
  - Without macro: `done` at T+32.
  - With macro: `done` at T+11.
- ROR, A=0x12345678, B=0; then op=3'b111, A=0xDEADBEEF, B=5 → `result`=0x12345678 at T+1, then `result`=0xDEADBEEF one cycle after the second start; no RUN cycles.
- SHL, A=0x0000FFFF, B=16 → `result`=0xFFFF0000.
  - During RUN, a start with ROL is ignored.
  - A second start (SHR, A=0xFFFF0000, B=16) issued during the `done` cycle is accepted and yields 0x0000FFFF with no idle gap.
- `clr` pulsed at RUN cycle 3 of SHR B=10 → next cycle `busy`=0, `done`=0, `result`=0; no `done` pulse follows.
